// File: rtl/uart_frame_rx.sv
// uart_frame_rx: UART receiver plus [HEADER][X][Y] frame parser.
// Recovers bytes from rx_serial (8N1, LSB first), checks frame structure and
// payload range, and publishes validated X/Y coordinates with error and frame
// counters for the state-estimation/display logic.
//
// Strobe semantics: frame_valid and frame_err are single-cycle, registered
// strobes with no back-pressure. When frame_valid is high, x_out/y_out already
// carry the new frame in that same cycle; the consumer must take it then.
// x_out/y_out hold their value between frame_valid strobes.
module uart_frame_rx #(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] HEADER       = 8'hFF,
  parameter logic [7:0] MAX_VAL      = 8'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_serial,
  output logic [7:0]  x_out,
  output logic [7:0]  y_out,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [15:0] frame_count,
  output logic [7:0]  err_count
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    B_IDLE  = 2'd0,
    B_START = 2'd1,
    B_DATA  = 2'd2,
    B_STOP  = 2'd3
  } bit_state_t;

  typedef enum logic [1:0] {
    F_HUNT    = 2'd0,
    F_GOT_HDR = 2'd1,
    F_GOT_X   = 2'd2
  } frm_state_t;

  logic          rx_meta;
  logic          rx_sync;
  bit_state_t    bit_state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          byte_ok;
  logic          byte_ferr;

  frm_state_t    frm_state;
  logic [7:0]    x_hold;
  logic          byte_is_hdr;
  logic          byte_in_range;
  logic          frm_err_evt;

  // Two-flop synchronizer; presets to the idle (high) line level on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
    end
  end

  // Bit-level receiver: mid-bit sampling, byte_ok/byte_ferr pulse after stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_state <= B_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      byte_ok   <= 1'b0;
      byte_ferr <= 1'b0;
    end else begin
      byte_ok   <= 1'b0;
      byte_ferr <= 1'b0;
      case (bit_state)
        B_IDLE: begin
          clk_cnt <= '0;
          if (!rx_sync) bit_state <= B_START;
        end
        B_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt   <= '0;
            bit_idx   <= '0;
            // A line that is high again at mid-start-bit was a glitch.
            bit_state <= rx_sync ? B_IDLE : B_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        B_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            shift   <= {rx_sync, shift[7:1]};
            if (bit_idx == 3'd7) bit_state <= B_STOP;
            else                 bit_idx   <= bit_idx + 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        B_STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt   <= '0;
            byte_ok   <= rx_sync;
            byte_ferr <= ~rx_sync;
            // Back to IDLE at mid-stop so a following start edge is not missed.
            bit_state <= B_IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: bit_state <= B_IDLE;
      endcase
    end
  end

  // Classify the received byte and decide whether this byte event is an error.
  always_comb begin
    byte_is_hdr   = (shift == HEADER);
    byte_in_range = (shift <= MAX_VAL);
    frm_err_evt   = 1'b0;
    if (byte_ferr) begin
      frm_err_evt = 1'b1;
    end else if (byte_ok) begin
      case (frm_state)
        F_GOT_HDR: frm_err_evt = !byte_is_hdr && !byte_in_range;
        F_GOT_X:   frm_err_evt = byte_is_hdr || !byte_in_range;
        default:   frm_err_evt = 1'b0;
      endcase
    end
  end

  // Frame parser: advances only on byte events, owns all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      frm_state   <= F_HUNT;
      x_hold      <= '0;
      x_out       <= '0;
      y_out       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;

      if (frm_err_evt) begin
        frame_err <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 1'b1;
      end

      if (byte_ferr) begin
        frm_state <= F_HUNT;
      end else if (byte_ok) begin
        case (frm_state)
          F_HUNT: begin
            if (byte_is_hdr) frm_state <= F_GOT_HDR;
          end
          F_GOT_HDR: begin
            if (byte_is_hdr) begin
              frm_state <= F_GOT_HDR;
            end else if (byte_in_range) begin
              x_hold    <= shift;
              frm_state <= F_GOT_X;
            end else begin
              frm_state <= F_HUNT;
            end
          end
          F_GOT_X: begin
            if (byte_is_hdr) begin
              // A header in the Y slot restarts the frame from this header.
              frm_state <= F_GOT_HDR;
            end else if (byte_in_range) begin
              x_out       <= x_hold;
              y_out       <= shift;
              frame_valid <= 1'b1;
              frame_count <= frame_count + 1'b1;
              frm_state   <= F_HUNT;
            end else begin
              frm_state <= F_HUNT;
            end
          end
          default: frm_state <= F_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed and randomized bench for uart_frame_rx.
// A byte-stream model (pending-frame queue) predicts frames and error counts;
// a monitor collects what the DUT publishes.
module tb_uart_frame_rx;

  localparam int         CPB  = 16;
  localparam logic [7:0] HDR  = 8'hFF;
  localparam logic [7:0] MAXV = 8'd15;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_serial = 1'b1;
  logic [7:0]  x_out;
  logic [7:0]  y_out;
  logic        frame_valid;
  logic        frame_err;
  logic [15:0] frame_count;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  uart_frame_rx #(
    .CLKS_PER_BIT(CPB),
    .HEADER      (HDR),
    .MAX_VAL     (MAXV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_serial  (rx_serial),
    .x_out      (x_out),
    .y_out      (y_out),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .frame_count(frame_count),
    .err_count  (err_count)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  logic [7:0]  pend[$];
  logic [15:0] exp_q[$];
  int          exp_err = 0;
  int          exp_frames = 0;
  logic [7:0]  exp_x = '0;
  logic [7:0]  exp_y = '0;

  task automatic model_byte(input logic [7:0] b, input bit ferr);
    if (ferr) begin
      exp_err++;
      pend.delete();
    end else if (pend.size() == 0) begin
      if (b == HDR) pend.push_back(b);
    end else if (b == HDR) begin
      if (pend.size() == 2) exp_err++;
      pend.delete();
      pend.push_back(b);
    end else if (b > MAXV) begin
      exp_err++;
      pend.delete();
    end else if (pend.size() == 1) begin
      pend.push_back(b);
    end else begin
      exp_q.push_back({pend[1], b});
      exp_x = pend[1];
      exp_y = b;
      exp_frames++;
      pend.delete();
    end
  endtask

  task automatic model_reset();
    pend.delete();
    exp_q.delete();
    exp_err    = 0;
    exp_frames = 0;
    exp_x      = '0;
    exp_y      = '0;
  endtask

  // ---------------- monitor ----------------
  int          cyc = 0;
  logic [15:0] got_q[$];
  int          err_pulses = 0;
  int          hold_viol = 0;
  int          both_viol = 0;
  int          fv_cyc = 0;
  int          last_start_cyc = 0;
  logic [7:0]  px = '0;
  logic [7:0]  py = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (frame_valid) begin
        got_q.push_back({x_out, y_out});
        fv_cyc = cyc;
      end else if (x_out !== px || y_out !== py) begin
        hold_viol++;
      end
      if (frame_err) err_pulses++;
      if (frame_valid && frame_err) both_viol++;
    end
    px = x_out;
    py = y_out;
  end

  // ---------------- checks ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    repeat (3 * CPB) @(negedge clk);
    check($sformatf("%s.nframes", tag), got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s.frame%0d", tag, i), got_q[i], exp_q[i]);
    check($sformatf("%s.err_pulses", tag), err_pulses, exp_err);
    check($sformatf("%s.err_count", tag), err_count, (exp_err > 255) ? 255 : exp_err);
    check($sformatf("%s.frame_count", tag), frame_count, exp_frames & 16'hFFFF);
    check($sformatf("%s.x_out", tag), x_out, exp_x);
    check($sformatf("%s.y_out", tag), y_out, exp_y);
    check($sformatf("%s.hold", tag), hold_viol, 0);
    check($sformatf("%s.overlap", tag), both_viol, 0);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check($sformatf("%s.x_out", tag), x_out, 0);
    check($sformatf("%s.y_out", tag), y_out, 0);
    check($sformatf("%s.frame_count", tag), frame_count, 0);
    check($sformatf("%s.err_count", tag), err_count, 0);
    check($sformatf("%s.strobes", tag), {frame_valid, frame_err}, 0);
  endtask

  // ---------------- drivers ----------------
  task automatic drive_bit(input logic v);
    rx_serial = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    last_start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    if (!stop_ok) drive_bit(1'b1);
    model_byte(b, !stop_ok);
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
    send_byte(c, 1'b1);
  endtask

  task automatic apply_reset();
    rx_serial = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    got_q.delete();
    err_pulses = 0;
    check_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int          lat;
    int          r;
    logic [7:0]  b;
    bit          stop_ok;

    @(negedge clk);
    apply_reset();

    // Basic back-to-back frame, plus start-edge-to-strobe latency.
    send3(8'hFF, 8'h05, 8'h0A);
    check_state("basic");
    lat = fv_cyc - last_start_cyc;
    check("latency_window", (lat >= 154 && lat <= 158) ? 1 : 0, 1);

    // Leading junk ignored in HUNT.
    send_byte(8'h37, 1'b1);
    send_byte(8'h12, 1'b1);
    send3(8'hFF, 8'h03, 8'h0C);
    check_state("junk");

    // Repeated headers resync without error.
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    send3(8'hFF, 8'h07, 8'h02);
    check_state("resync");

    // Header in the Y slot: one error, then a good frame from that header.
    send_byte(8'hFF, 1'b1);
    send_byte(8'h04, 1'b1);
    send3(8'hFF, 8'h09, 8'h01);
    check_state("hdr_in_y");

    // Out-of-range X: error, trailing byte ignored, outputs hold.
    send3(8'hFF, 8'h20, 8'h05);
    check_state("bad_x");

    // Framing error on the X byte.
    send_byte(8'hFF, 1'b1);
    send_byte(8'h06, 1'b0);
    check_state("stop_low");

    // Short low glitch on an idle line.
    rx_serial = 1'b0;
    repeat (3) @(negedge clk);
    rx_serial = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_state("glitch");

    // Reset in the middle of the Y byte, then a clean frame.
    send_byte(8'hFF, 1'b1);
    send_byte(8'h05, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    apply_reset();
    check_state("after_rst");
    send3(8'hFF, 8'h01, 8'h02);
    check_state("post_rst_frame");

    // Randomized byte stream.
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      b = HDR;
      else if (r < 75) b = 8'($urandom_range(0, 15));
      else             b = 8'($urandom_range(16, 254));
      stop_ok = ($urandom_range(0, 19) != 0);
      send_byte(b, stop_ok);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    check_state("random");

    // Error counter saturation via framing errors.
    for (int k = 0; k < 260; k++) begin
      send_byte(8'($urandom_range(0, 255)), 1'b0);
    end
    check_state("saturate");
    check("sat_value", err_count, 8'hFF);

    // Frames still decode with a saturated error counter.
    send3(8'hFF, 8'h0F, 8'h00);
    check_state("post_sat");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
